// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer owning HI/LO with fixed multi-cycle latency and D-stage stall
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata_E,
  output logic        stall_D
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] pend_hi, pend_lo, pend_hi_n, pend_lo_n, hi_n, lo_n;
  logic pend_wr, pend_wr_n, done;
  logic is_mul, is_div, dz, ovf;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dv_s, dv_u, q_s, r_s, q_u, r_u, res_hi, res_lo;
  // Result datapath; divisors are forced to 1 for divide-by-zero and the signed
  // overflow case so the dividers never see an undefined operation (INT_MIN/1 gives
  // quotient 0x80000000, remainder 0 as required).
  always_comb begin
    is_mul = md_op_E == 4'd1 || md_op_E == 4'd2;
    is_div = md_op_E == 4'd3 || md_op_E == 4'd4;
    dz = rt_E == 32'd0;
    ovf = rs_E == 32'h8000_0000 && rt_E == 32'hFFFF_FFFF;
    prod_s = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
    prod_u = {32'd0, rs_E} * {32'd0, rt_E};
    dv_s = (dz | ovf) ? 32'd1 : rt_E;
    dv_u = dz ? 32'd1 : rt_E;
    q_s = $signed(rs_E) / $signed(dv_s);
    r_s = $signed(rs_E) % $signed(dv_s);
    q_u = rs_E / dv_u;
    r_u = rs_E % dv_u;
    res_hi = md_op_E == 4'd1 ? prod_s[63:32] : md_op_E == 4'd2 ? prod_u[63:32] :
             md_op_E == 4'd3 ? r_s : r_u;
    res_lo = md_op_E == 4'd1 ? prod_s[31:0] : md_op_E == 4'd2 ? prod_u[31:0] :
             md_op_E == 4'd3 ? q_s : q_u;
  end
  // State register and HI/LO/pending result storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
      hi <= hi_n;
      lo <= lo_n;
    end
  end
  // Next state: latch result on start, count down while running, commit on the last cycle
  always_comb begin
    done = busy && cnt == CW'(1);
    state_n = start ? RUN : done ? IDLE : state;
    cnt_n = start ? (is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) : busy ? cnt - CW'(1) : cnt;
    pend_hi_n = start ? res_hi : pend_hi;
    pend_lo_n = start ? res_lo : pend_lo;
    pend_wr_n = start ? ~(is_div & dz) : pend_wr;
    hi_n = (done & pend_wr) ? pend_hi : (!busy && md_op_E == 4'd7) ? rs_E : hi;
    lo_n = (done & pend_wr) ? pend_lo : (!busy && md_op_E == 4'd8) ? rs_E : lo;
  end
  // Outputs: busy from state, start/stall/read data straight from E-stage inputs
  always_comb begin
    busy = state == RUN;
    start = (is_mul | is_div) & ~busy;
    md_rdata_E = md_op_E == 4'd5 ? hi : md_op_E == 4'd6 ? lo : 32'd0;
    stall_D = md_use_D & (start | busy);
  end
endmodule
